// File: rtl/pipelined_carry_select_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_carry_select_adder
// Purpose  : Parametrised, pipelined carry-select adder/subtractor with
//            valid/ready flow control. Operands are split into BLOCK_SIZE-bit
//            blocks. BLOCKS_PER_STAGE blocks are resolved in each register
//            stage.
// Options  : PIPE_CSA_OVF_EN adds out_ovf, the pipelined two's-complement
//            overflow flag of the effective addition.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_carry_select_adder #(
    parameter int WIDTH            = 32,
    parameter int BLOCK_SIZE       = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef PIPE_CSA_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    // Guarded copies keep the derived constants finite even for an illegal
    // parameter set, so the elaboration error below is the one reported.
    localparam int c_BS     = (BLOCK_SIZE < 1) ? 1 : BLOCK_SIZE;
    localparam int c_BPS    = (BLOCKS_PER_STAGE < 1) ? 1 : BLOCKS_PER_STAGE;
    localparam int c_NB     = (WIDTH / c_BS < 1) ? 1 : WIDTH / c_BS;
    localparam int c_STAGES = (c_NB + c_BPS - 1) / c_BPS;
    localparam int c_LAST   = c_STAGES - 1;

    if ((WIDTH < 1) || (BLOCK_SIZE < 1) || (BLOCKS_PER_STAGE < 1) ||
        ((WIDTH % c_BS) != 0)) begin : g_param_error
        $error("pipelined_carry_select_adder: illegal WIDTH/BLOCK_SIZE/BLOCKS_PER_STAGE");
    end

    // Stage registers. Each stage carries the full operand words; the bits
    // already resolved are simply never read again downstream.
    logic             r_valid [c_STAGES];
    logic             r_carry [c_STAGES];
    logic [WIDTH-1:0] r_sum   [c_STAGES];
    logic [WIDTH-1:0] r_a     [c_STAGES];
    logic [WIDTH-1:0] r_b     [c_STAGES];

    // Per-stage inputs (predecessor register or the issue port) and results.
    logic             w_src_valid [c_STAGES];
    logic             w_src_carry [c_STAGES];
    logic [WIDTH-1:0] w_src_sum   [c_STAGES];
    logic [WIDTH-1:0] w_src_a     [c_STAGES];
    logic [WIDTH-1:0] w_src_b     [c_STAGES];
    logic             w_nxt_carry [c_STAGES];
    logic [WIDTH-1:0] w_nxt_sum   [c_STAGES];

    logic             w_adv;

    // The whole pipe moves in lockstep; it only freezes when the result
    // register is full and the consumer is not taking it.
    assign w_adv     = !r_valid[c_LAST] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[c_LAST];
    assign out_sum   = r_sum[c_LAST];
    assign out_cout  = r_carry[c_LAST];

    // Route the issue port into stage 0 and each register into its successor.
    always_comb begin
        w_src_valid[0] = in_valid & w_adv;
        w_src_carry[0] = in_sub ? 1'b1 : in_cin;
        w_src_sum[0]   = '0;
        w_src_a[0]     = in_a;
        w_src_b[0]     = in_sub ? ~in_b : in_b;
        for (int k = 1; k < c_STAGES; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_carry[k] = r_carry[k-1];
            w_src_sum[k]   = r_sum[k-1];
            w_src_a[k]     = r_a[k-1];
            w_src_b[k]     = r_b[k-1];
        end
    end

    // Carry-select resolution of the blocks owned by each stage: both block
    // sums are formed up front and the rippling block carry picks one.
    always_comb begin : p_resolve
        logic [c_BS:0]    v_s0;
        logic [c_BS:0]    v_s1;
        logic [c_BS:0]    v_sel;
        logic             v_carry;
        logic [WIDTH-1:0] v_sum;
        v_s0    = '0;
        v_s1    = '0;
        v_sel   = '0;
        v_carry = 1'b0;
        v_sum   = '0;
        for (int k = 0; k < c_STAGES; k++) begin
            v_carry = w_src_carry[k];
            v_sum   = w_src_sum[k];
            for (int j = 0; j < c_NB; j++) begin
                if ((j / c_BPS) == k) begin
                    v_s0  = {1'b0, w_src_a[k][j*c_BS +: c_BS]}
                          + {1'b0, w_src_b[k][j*c_BS +: c_BS]};
                    v_s1  = {1'b0, w_src_a[k][j*c_BS +: c_BS]}
                          + {1'b0, w_src_b[k][j*c_BS +: c_BS]}
                          + {{c_BS{1'b0}}, 1'b1};
                    v_sel = v_carry ? v_s1 : v_s0;
                    v_sum[j*c_BS +: c_BS] = v_sel[c_BS-1:0];
                    v_carry = v_sel[c_BS];
                end
            end
            w_nxt_carry[k] = v_carry;
            w_nxt_sum[k]   = v_sum;
        end
    end

    // Stage registers: cleared by reset, loaded together on every advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_carry[k] <= 1'b0;
                r_sum[k]   <= '0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < c_STAGES; k++) begin
                r_valid[k] <= w_src_valid[k];
                r_carry[k] <= w_nxt_carry[k];
                r_sum[k]   <= w_nxt_sum[k];
                r_a[k]     <= w_src_a[k];
                r_b[k]     <= w_src_b[k];
            end
        end
    end

`ifdef PIPE_CSA_OVF_EN
    logic w_nxt_ovf;
    logic r_ovf;

    // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
    always_comb begin
        w_nxt_ovf = w_src_a[c_LAST][WIDTH-1] ^ w_src_b[c_LAST][WIDTH-1]
                  ^ w_nxt_sum[c_LAST][WIDTH-1] ^ w_nxt_carry[c_LAST];
    end

    // Overflow flag travels with the final-stage result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_nxt_ovf;
        end
    end

    assign out_ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_select_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_carry_select_adder
// Purpose  : Directed, table-driven bench for pipelined_carry_select_adder
//            (WIDTH=16, BLOCK_SIZE=4, BLOCKS_PER_STAGE=2, two stages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_carry_select_adder;

    localparam int WIDTH = 16;
    localparam int NVEC  = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef PIPE_CSA_OVF_EN
    logic             out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [NVEC];

    pipelined_carry_select_adder #(
        .WIDTH            (16),
        .BLOCK_SIZE       (4),
        .BLOCKS_PER_STAGE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef PIPE_CSA_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        in_cin   = 1'b0;
        in_sub   = 1'b0;
    endtask

    initial begin
        //          a         b         cin   sub   sum       cout  ovf
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[3]  = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
        vecs[4]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[10] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_sum",   {16'b0, out_sum},   32'd0);
        chk("reset out_cout",  {31'b0, out_cout},  32'd0);
        chk("reset in_ready",  {31'b0, in_ready},  32'd1);
`ifdef PIPE_CSA_OVF_EN
        chk("reset out_ovf",   {31'b0, out_ovf},   32'd0);
`endif

        // Single beat with full carry ripple: valid for exactly one cycle
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        chk("ripple valid early", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("ripple valid",      {31'b0, out_valid}, 32'd1);
        chk("ripple sum",        {16'b0, out_sum},   32'h0000);
        chk("ripple cout",       {31'b0, out_cout},  32'd1);
        @(negedge clk);
        chk("ripple valid after", {31'b0, out_valid}, 32'd0);

        // Table applied back to back at full rate
        for (int t = 0; t < NVEC + 2; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                chk($sformatf("vec%0d valid", t-2), {31'b0, out_valid}, 32'd1);
                chk($sformatf("vec%0d sum",   t-2), {16'b0, out_sum},   {16'b0, vecs[t-2].sum});
                chk($sformatf("vec%0d cout",  t-2), {31'b0, out_cout},  {31'b0, vecs[t-2].cout});
`ifdef PIPE_CSA_OVF_EN
                chk($sformatf("vec%0d ovf",   t-2), {31'b0, out_ovf},   {31'b0, vecs[t-2].ovf});
`endif
            end
            if (t < NVEC) drive(vecs[t].a, vecs[t].b, vecs[t].cin, vecs[t].sub);
            else          idle();
        end
        @(negedge clk);
        chk("stream drained valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: fill both stages, stall 5 cycles, then drain
        out_ready = 1'b0;
        drive(16'h0010, 16'h0020, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp fill in_ready", {31'b0, in_ready}, 32'd1);
        drive(16'h0100, 16'h0200, 1'b0, 1'b0);
        @(negedge clk);
        drive(16'h1000, 16'h2000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp stall%0d valid", i),    {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp stall%0d sum", i),      {16'b0, out_sum},   32'h0030);
            chk($sformatf("bp stall%0d in_ready", i), {31'b0, in_ready},  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp release sum",      {16'b0, out_sum},  32'h0030);
        @(negedge clk);
        idle();
        chk("bp beat2 valid", {31'b0, out_valid}, 32'd1);
        chk("bp beat2 sum",   {16'b0, out_sum},   32'h0300);
        @(negedge clk);
        chk("bp beat3 valid", {31'b0, out_valid}, 32'd1);
        chk("bp beat3 sum",   {16'b0, out_sum},   32'h3000);
        @(negedge clk);
        chk("bp drained valid", {31'b0, out_valid}, 32'd0);

        // Reset with beats in flight: neither may ever emerge
        drive(16'h0101, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        drive(16'h0202, 16'h0202, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        chk("rst pre valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst async valid", {31'b0, out_valid}, 32'd0);
        chk("rst async sum",   {16'b0, out_sum},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst after%0d valid", i), {31'b0, out_valid}, 32'd0);
        end
        drive(16'h4444, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("rst new beat valid", {31'b0, out_valid}, 32'd1);
        chk("rst new beat sum",   {16'b0, out_sum},   32'h5555);
        chk("rst new beat cout",  {31'b0, out_cout},  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
